// File: rtl/femto_mem_pkg.sv
// Shared types and constants for the single-port memory arbiter.
package femto_mem_pkg;

    // Arbiter control states: free to grant, or waiting on a read return.
    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } arb_state_t;

    // Requester identifiers; also the bit positions in the request vector.
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Longest supported memory read latency and the counter width to hold it.
    localparam int MAX_RD_LAT = 4;
    localparam int CNT_W      = 3;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-way round-robin selector. On a tie the port that did not win most
// recently is chosen; the history only advances when the caller grants.
module rr_pick2
    import femto_mem_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic [1:0] req,
    input  logic       update,
    output logic       pick,
    output logic       active
);

    logic last_gnt_reg;

    // Winner selection: a lone requester wins, a tie goes against last_gnt.
    always_comb begin
        active = |req;
        if (req[PORT_I] && req[PORT_D]) begin
            pick = ~last_gnt_reg;
        end else if (req[PORT_D]) begin
            pick = PORT_D;
        end else begin
            pick = PORT_I;
        end
    end

    // Remember the last granted port; resets to data so fetch wins first tie.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            last_gnt_reg <= PORT_D;
        end else if (update) begin
            last_gnt_reg <= pick;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port word memory between instruction fetch and
// load/store. At most one access per cycle; reads are tracked with a
// latency counter so the returning data is steered to its issuer.
module mem_arbiter
    import femto_mem_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    input  logic [3:0]        d_wmask,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              m_en,
    output logic [3:0]        m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wdata,
    input  logic [31:0]       m_rdata,
    output logic              busy
);

    if (RD_LAT < 1 || RD_LAT > MAX_RD_LAT) begin : g_bad_lat
        $error("mem_arbiter: RD_LAT must be within 1..4");
    end

    arb_state_t       state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             owner_reg, owner_next;

    logic rd_done;
    logic can_grant;
    logic grant;
    logic win;
    logic any_req;

    // The last wait cycle both returns data and acts as IDLE.
    assign rd_done   = (state_reg == RD_WAIT) && (cnt_reg == CNT_W'(1));
    assign can_grant = resetn && ((state_reg == IDLE) || rd_done);
    assign grant     = can_grant && any_req;

    rr_pick2 u_pick (
        .clk    (clk),
        .resetn (resetn),
        .req    ({d_req, i_req}),
        .update (grant),
        .pick   (win),
        .active (any_req)
    );

    // Next-state, counter and memory-side mux; everything idles at zero.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        owner_next = owner_reg;
        i_gnt      = 1'b0;
        d_gnt      = 1'b0;
        m_en       = 1'b0;
        m_we       = 4'b0000;
        m_addr     = '0;
        m_wdata    = '0;

        if (state_reg == RD_WAIT) begin
            if (rd_done) begin
                state_next = IDLE;
            end else begin
                cnt_next = cnt_reg - CNT_W'(1);
            end
        end

        if (grant) begin
            m_en = 1'b1;
            if (win == PORT_I) begin
                i_gnt  = 1'b1;
                m_addr = i_addr;
            end else begin
                d_gnt   = 1'b1;
                m_addr  = d_addr;
                m_wdata = d_wdata;
                if (d_we) begin
                    m_we = d_wmask;
                end
            end
            // A zero-mask write is still a write: no wait state.
            if ((win == PORT_I) || !d_we) begin
                state_next = RD_WAIT;
                cnt_next   = CNT_W'(RD_LAT);
                owner_next = win;
            end
        end
    end

    // State, latency counter and read-owner registers.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            owner_reg <= PORT_I;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            owner_reg <= owner_next;
        end
    end

    assign i_rvalid = resetn && rd_done && (owner_reg == PORT_I);
    assign d_rvalid = resetn && rd_done && (owner_reg == PORT_D);
    assign i_rdata  = m_rdata;
    assign d_rdata  = m_rdata;
    assign busy     = resetn && (state_reg == RD_WAIT);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: instance 0 uses RD_LAT=1, instance 1 RD_LAT=2.
// Stimulus queues expected grants/returns; per-instance monitors check them.
module tb_mem_arbiter;

    typedef struct {
        logic        port;
        logic [7:0]  addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        logic        rd;
    } gnt_t;

    typedef struct {
        logic        port;
        logic [31:0] data;
    } rv_t;

    logic clk;
    int   cyc;
    int   n_checks;
    int   n_fail;

    logic        resetn   [2];
    logic        i_req    [2];
    logic [7:0]  i_addr   [2];
    logic        i_gnt    [2];
    logic        i_rvalid [2];
    logic [31:0] i_rdata  [2];
    logic        d_req    [2];
    logic        d_we     [2];
    logic [7:0]  d_addr   [2];
    logic [31:0] d_wdata  [2];
    logic [3:0]  d_wmask  [2];
    logic        d_gnt    [2];
    logic        d_rvalid [2];
    logic [31:0] d_rdata  [2];
    logic        m_en     [2];
    logic [3:0]  m_we     [2];
    logic [7:0]  m_addr   [2];
    logic [31:0] m_wdata  [2];
    logic [31:0] m_rdata  [2];
    logic        busy     [2];

    logic [31:0] mem     [2][256];
    logic [31:0] rd_pipe [2][4];

    gnt_t gnt_q  [2][$];
    rv_t  rv_q   [2][$];
    int   gcyc_q [2][$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    function automatic void check(input int k, input string name,
                                  input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] cyc %0d: got 0x%08h expected 0x%08h", name, k, cyc, act, exp);
        end
    endfunction

    function automatic void miss(input int k, input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s[%0d] cyc %0d: event without matching expectation", name, k, cyc);
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        mem_arbiter #(.ADDR_W(8), .RD_LAT(gi + 1)) u_dut (
            .clk      (clk),
            .resetn   (resetn[gi]),
            .i_req    (i_req[gi]),
            .i_addr   (i_addr[gi]),
            .i_gnt    (i_gnt[gi]),
            .i_rvalid (i_rvalid[gi]),
            .i_rdata  (i_rdata[gi]),
            .d_req    (d_req[gi]),
            .d_we     (d_we[gi]),
            .d_addr   (d_addr[gi]),
            .d_wdata  (d_wdata[gi]),
            .d_wmask  (d_wmask[gi]),
            .d_gnt    (d_gnt[gi]),
            .d_rvalid (d_rvalid[gi]),
            .d_rdata  (d_rdata[gi]),
            .m_en     (m_en[gi]),
            .m_we     (m_we[gi]),
            .m_addr   (m_addr[gi]),
            .m_wdata  (m_wdata[gi]),
            .m_rdata  (m_rdata[gi]),
            .busy     (busy[gi])
        );

        assign m_rdata[gi] = rd_pipe[gi][gi];

        // Memory model: byte writes, read data after gi+1 cycles, junk otherwise.
        initial forever begin
            @(posedge clk);
            for (int s = 3; s > 0; s--) rd_pipe[gi][s] <= rd_pipe[gi][s-1];
            if (m_en[gi] && m_we[gi] == 4'b0000) rd_pipe[gi][0] <= mem[gi][m_addr[gi]];
            else rd_pipe[gi][0] <= 32'hFFFF_FFFF;
            if (m_en[gi]) begin
                for (int b = 0; b < 4; b++)
                    if (m_we[gi][b]) mem[gi][m_addr[gi]][8*b +: 8] <= m_wdata[gi][8*b +: 8];
            end
        end

        // Monitor: compare every grant and every read return against the queues.
        initial begin
            gnt_t e;
            rv_t  r;
            int   g;
            forever begin
                @(negedge clk);
                if (!resetn[gi]) begin
                    gcyc_q[gi].delete();
                end else begin
                    if (i_gnt[gi] || d_gnt[gi]) begin
                        if (gnt_q[gi].size() == 0) begin
                            miss(gi, "unexpected_gnt");
                        end else begin
                            e = gnt_q[gi].pop_front();
                            $display("gnt[%0d] cyc %0d port %0d addr 0x%02h we %b", gi, cyc, d_gnt[gi], m_addr[gi], m_we[gi]);
                            check(gi, "gnt_port", 32'(d_gnt[gi]), 32'(e.port));
                            check(gi, "gnt_excl", 32'(i_gnt[gi] && d_gnt[gi]), 32'd0);
                            check(gi, "gnt_m_en", 32'(m_en[gi]), 32'd1);
                            check(gi, "gnt_m_addr", 32'(m_addr[gi]), 32'(e.addr));
                            check(gi, "gnt_m_we", 32'(m_we[gi]), 32'(e.we));
                            if (!e.rd) check(gi, "gnt_m_wdata", m_wdata[gi], e.wdata);
                            if (e.rd) gcyc_q[gi].push_back(cyc);
                        end
                    end
                    if (i_rvalid[gi] || d_rvalid[gi]) begin
                        if (rv_q[gi].size() == 0 || gcyc_q[gi].size() == 0) begin
                            miss(gi, "unexpected_rvalid");
                        end else begin
                            r = rv_q[gi].pop_front();
                            g = gcyc_q[gi].pop_front();
                            $display("rv[%0d] cyc %0d port %0d data 0x%08h", gi, cyc, d_rvalid[gi],
                                     d_rvalid[gi] ? d_rdata[gi] : i_rdata[gi]);
                            check(gi, "rv_port", 32'(d_rvalid[gi]), 32'(r.port));
                            check(gi, "rv_excl", 32'(i_rvalid[gi] && d_rvalid[gi]), 32'd0);
                            check(gi, "rv_data", d_rvalid[gi] ? d_rdata[gi] : i_rdata[gi], r.data);
                            check(gi, "rv_latency", 32'(cyc - g), 32'(gi + 1));
                        end
                    end
                end
            end
        end
    end

    task automatic push_gnt(input int k, input logic port, input logic [7:0] addr,
                            input logic [3:0] we, input logic [31:0] wdata, input logic rd);
        gnt_t e;
        e.port = port; e.addr = addr; e.we = we; e.wdata = wdata; e.rd = rd;
        gnt_q[k].push_back(e);
    endtask

    task automatic push_rv(input int k, input logic port, input logic [31:0] data);
        rv_t r;
        r.port = port; r.data = data;
        rv_q[k].push_back(r);
    endtask

    // Returns at the negedge where the port's grant is visible, or times out.
    task automatic wait_gnt(input int k, input logic port, input int budget);
        bit found;
        found = 1'b0;
        for (int n = 0; n < budget && !found; n++) begin
            @(negedge clk);
            if (port ? d_gnt[k] : i_gnt[k]) found = 1'b1;
        end
        if (!found) miss(k, "gnt_timeout");
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ngnt;
        n_checks = 0;
        n_fail   = 0;
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 256; a++) mem[k][a] = 32'h0;
            for (int s = 0; s < 4; s++) rd_pipe[k][s] = 32'h0;
            resetn[k] = 1'b0;
            i_req[k] = 1'b0; i_addr[k] = 8'h00;
            d_req[k] = 1'b0; d_we[k] = 1'b0; d_addr[k] = 8'h00;
            d_wdata[k] = 32'h0; d_wmask[k] = 4'h0;
        end
        mem[0][8'h05] = 32'h0010_0093;
        mem[0][8'h20] = 32'hDEAD_BEEF;
        mem[0][8'h21] = 32'h1234_5678;
        mem[0][8'h10] = 32'h1122_3344;
        mem[1][8'h03] = 32'hCAFE_F00D;
        mem[1][8'h07] = 32'h0BAD_C0DE;

        // Reset with both ports requesting: nothing may be granted or strobed.
        i_req[0] = 1'b1; i_addr[0] = 8'h20;
        d_req[0] = 1'b1; d_addr[0] = 8'h21;
        repeat (3) begin
            @(negedge clk);
            check(0, "rst_i_gnt", 32'(i_gnt[0]), 32'd0);
            check(0, "rst_d_gnt", 32'(d_gnt[0]), 32'd0);
            check(0, "rst_rvalid", 32'(i_rvalid[0] | d_rvalid[0]), 32'd0);
            check(0, "rst_m_en", 32'(m_en[0]), 32'd0);
            check(0, "rst_m_we", 32'(m_we[0]), 32'd0);
            check(0, "rst_m_addr", 32'(m_addr[0]), 32'd0);
            check(0, "rst_m_wdata", m_wdata[0], 32'd0);
            check(0, "rst_busy", 32'(busy[0]), 32'd0);
        end

        // Contention from reset: I, D, I, D, I, D with alternating returns.
        for (int n = 0; n < 3; n++) begin
            push_gnt(0, 1'b0, 8'h20, 4'h0, 32'h0, 1'b1);
            push_gnt(0, 1'b1, 8'h21, 4'h0, 32'h0, 1'b1);
            push_rv(0, 1'b0, 32'hDEAD_BEEF);
            push_rv(0, 1'b1, 32'h1234_5678);
        end
        step;
        resetn[0] = 1'b1;
        resetn[1] = 1'b1;
        ngnt = 0;
        for (int n = 0; n < 20 && ngnt < 6; n++) begin
            @(negedge clk);
            if (i_gnt[0] || d_gnt[0]) ngnt++;
        end
        if (ngnt < 6) miss(0, "contention_timeout");
        step;
        i_req[0] = 1'b0; d_req[0] = 1'b0;
        repeat (3) step;

        // Single fetch from address 5.
        push_gnt(0, 1'b0, 8'h05, 4'h0, 32'h0, 1'b1);
        push_rv(0, 1'b0, 32'h0010_0093);
        i_req[0] = 1'b1; i_addr[0] = 8'h05;
        wait_gnt(0, 1'b0, 10);
        step;
        i_req[0] = 1'b0;
        repeat (3) step;

        // Byte store (data wins, fetch won last) with a fetch pending behind it.
        push_gnt(0, 1'b1, 8'h10, 4'b0010, 32'hAABB_CCDD, 1'b0);
        push_gnt(0, 1'b0, 8'h20, 4'h0, 32'h0, 1'b1);
        push_rv(0, 1'b0, 32'hDEAD_BEEF);
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 8'h10;
        d_wdata[0] = 32'hAABB_CCDD; d_wmask[0] = 4'b0010;
        i_req[0] = 1'b1; i_addr[0] = 8'h20;
        @(negedge clk);
        check(0, "st_d_gnt", 32'(d_gnt[0]), 32'd1);
        check(0, "st_i_held", 32'(i_gnt[0]), 32'd0);
        check(0, "st_busy", 32'(busy[0]), 32'd0);
        step;
        d_req[0] = 1'b0; d_we[0] = 1'b0;
        @(negedge clk);
        check(0, "st_i_next", 32'(i_gnt[0]), 32'd1);
        step;
        i_req[0] = 1'b0;
        repeat (3) step;

        // Zero-mask write, then a fetch reading back the byte-merged word.
        push_gnt(0, 1'b1, 8'h30, 4'h0, 32'h5555_5555, 1'b0);
        push_gnt(0, 1'b0, 8'h10, 4'h0, 32'h0, 1'b1);
        push_rv(0, 1'b0, 32'h1122_CC44);
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 8'h30;
        d_wdata[0] = 32'h5555_5555; d_wmask[0] = 4'b0000;
        i_req[0] = 1'b1; i_addr[0] = 8'h10;
        @(negedge clk);
        check(0, "wm0_d_gnt", 32'(d_gnt[0]), 32'd1);
        check(0, "wm0_m_en", 32'(m_en[0]), 32'd1);
        check(0, "wm0_busy", 32'(busy[0]), 32'd0);
        step;
        d_req[0] = 1'b0; d_we[0] = 1'b0;
        @(negedge clk);
        check(0, "wm0_i_next", 32'(i_gnt[0]), 32'd1);
        check(0, "wm0_busy_next", 32'(busy[0]), 32'd0);
        step;
        i_req[0] = 1'b0;
        @(negedge clk);
        check(0, "rd_busy", 32'(busy[0]), 32'd1);
        repeat (3) step;

        // RD_LAT=2: reset right after a data read grant drops the read.
        push_gnt(1, 1'b1, 8'h07, 4'h0, 32'h0, 1'b1);
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 8'h07;
        wait_gnt(1, 1'b1, 10);
        step;
        d_req[1] = 1'b0;
        resetn[1] = 1'b0;
        @(negedge clk);
        check(1, "mid_rst_busy", 32'(busy[1]), 32'd0);
        check(1, "mid_rst_rvalid", 32'(d_rvalid[1]), 32'd0);
        step;
        step;
        resetn[1] = 1'b1;
        repeat (5) step;

        push_gnt(1, 1'b1, 8'h03, 4'h0, 32'h0, 1'b1);
        push_rv(1, 1'b1, 32'hCAFE_F00D);
        d_req[1] = 1'b1; d_addr[1] = 8'h03;
        wait_gnt(1, 1'b1, 10);
        step;
        d_req[1] = 1'b0;
        @(negedge clk);
        check(1, "lat2_busy", 32'(busy[1]), 32'd1);
        check(1, "lat2_rvalid_early", 32'(d_rvalid[1]), 32'd0);

        // Let outstanding expectations drain, then confirm nothing was left over.
        for (int n = 0; n < 20; n++) begin
            if (gnt_q[0].size() == 0 && gnt_q[1].size() == 0 &&
                rv_q[0].size() == 0 && rv_q[1].size() == 0) break;
            step;
        end
        repeat (3) step;
        for (int k = 0; k < 2; k++) begin
            check(k, "gnt_q_left", 32'(gnt_q[k].size()), 32'd0);
            check(k, "rv_q_left", 32'(rv_q[k].size()), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter that shares the single-port, word-addressed program/data memory between the processor's instruction-fetch port and its load/store port. It sits between the core's control state machine and the memory array, and issues at most one memory access per cycle. Conflicts are resolved round-robin, and each read result is returned to the requester that issued it. This removes the need for a separate instruction and data memory once loads and stores are added to the core.

## Interface
Parameters:
- ADDR_W, 8, word-address width (default gives 256 words).
- RD_LAT, 1, memory read latency in cycles from the `m_en` cycle to valid `m_rdata`. Legal values are 1..4.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset: synchronous, active-low.
- i_req  in  1  instruction read request.
- i_addr  in  ADDR_W  instruction word address.
- i_gnt  out  1  instruction request accepted this cycle.
- i_rvalid  out  1  `i_rdata` valid this cycle.
- i_rdata  out  32  instruction read data.
- d_req  in  1  data request.
- d_we  in  1  1 = write, 0 = read.
- d_addr  in  ADDR_W  data word address.
- d_wdata  in  32  write data.
- d_wmask  in  4  byte write enables.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  `d_rdata` valid this cycle.
- d_rdata  out  32  data read data.
- m_en  out  1  memory access strobe.
- m_we  out  4  byte write mask to memory; 0 means read.
- m_addr  out  ADDR_W  memory address.
- m_wdata  out  32  memory write data.
- m_rdata  in  32  memory read data.
- busy  out  1  a read is outstanding.

## Operation
**Handshake**
- A requester holds `req` and its address/data stable until it sees `gnt` high.
- The access takes effect in the `gnt` cycle; `gnt` is a one-cycle pulse.
- `gnt` is combinational from `req` and internal state.

**State machine**
- IDLE:
  - If no request, `m_en` is 0.
  - Otherwise pick a winner, assert its `gnt` and `m_en`, and drive `m_addr`/`m_wdata`/`m_we` from the winner.
  - A read latches the owner, loads the latency counter with RD_LAT, and goes to RD_WAIT.
  - A write stays in IDLE with `m_we = d_wmask`.
- RD_WAIT:
  - No grants.
  - The counter decrements each cycle.
  - In the cycle the counter reaches the end, assert the owner's `rvalid` for one cycle. That same cycle behaves as IDLE and may grant a new request.

**Arbitration**
- Only one requester active: it wins.
- Both active: the port not granted most recently wins.
- `last_gnt` resets to the data port, so instruction fetch wins the first tie.

**Routing and corner cases**
- `i_rdata` and `d_rdata` are both driven from `m_rdata`; they are meaningful only when the matching `rvalid` is high.
- Writes produce no `rvalid` and no wait state.
- Data write with `d_wmask == 0`: granted and `m_en` asserted with `m_we = 0`. It is treated internally as a write: no RD_WAIT, no `rvalid`, and `m_rdata` is ignored.
- Reset mid-read: return to IDLE. The pending read is dropped and no `rvalid` is ever issued for it; later `m_rdata` is ignored.
- `busy` is 1 in RD_WAIT.

## Timing
- Reset values: all `gnt` = 0, all `rvalid` = 0, `m_en` = 0, `m_we` = 0, `busy` = 0, `m_addr` = 0, `m_wdata` = 0, state IDLE, `last_gnt` = data.
- Read latency: grant in cycle T, `rvalid` in cycle T+RD_LAT.
- Read throughput: one read per RD_LAT cycles; with RD_LAT = 1, back-to-back reads are granted every cycle.
- Write: one cycle, and a write may be granted every cycle.
- Simultaneous `rvalid` and a new grant in the same cycle is legal and required.
- `i_rvalid` and `d_rvalid` are never high together.

## Structure
- Shared package `femto_mem_pkg`:
  - state enum `{IDLE, RD_WAIT}`;
  - port-ID constants `PORT_I = 0`, `PORT_D = 1`;
  - `MAX_RD_LAT = 4`.
- One sub-module is natural: `rr_pick2`, the 2-way round-robin selector with a registered `last_gnt` and an update-on-grant input.
- Counter, FSM and mux logic stay in `mem_arbiter`.

## Test plan
1. Reset: hold `resetn = 0` for 3 cycles with `i_req = d_req = 1` -> all outputs 0, no grants.
2. Single fetch, RD_LAT = 1: `i_addr = 0x05`, mem[5] = 0x00100093 -> `i_gnt` and `m_en` at T with `m_addr = 5` and `m_we = 0`; `i_rvalid` at T+1 with `i_rdata = 0x00100093`.
3. Contention: both ports reading continuously from reset -> grants alternate I, D, I, D…; `rvalid`s alternate the same way and never overlap.
4. Byte store: `d_we = 1`, `d_addr = 0x10`, `d_wdata = 0xAABBCCDD`, `d_wmask = 0010` -> `m_we = 0010` in the grant cycle; no `d_rvalid`; a pending `i_req` is granted the next cycle.
5. RD_LAT = 2: reset asserted at T+1 after a `d` read grant -> no `d_rvalid` ever; after reset release, a new read at address 3 returns mem[3] at grant+2.
6. `d_wmask = 0` write -> `d_gnt` with `m_en = 1` and `m_we = 0`; `busy` stays 0; no `rvalid`; a following `i_req` is granted the next cycle.
